// File: rtl/dp_request_arbiter_pkg.sv
// Shared widths, FSM state encodings and instruction field layout for the draw-datapath arbiter.
package dp_request_arbiter_pkg;

    localparam int INSTRUCTION_WIDTH = 32;
    localparam int RESULT_WIDTH      = 16;

    // Opcode occupies the top nibble of a draw instruction.
    localparam int OP_MSB = 31;
    localparam int OP_LSB = 28;
    localparam int OP_W   = OP_MSB - OP_LSB + 1;

    typedef enum logic [2:0] {
        DPARB_IDLE   = 3'd0,
        DPARB_ISSUE  = 3'd1,
        DPARB_SETTLE = 3'd2,
        DPARB_WAIT   = 3'd3,
        DPARB_RESP   = 3'd4
    } dparb_state_e;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [8:0]      pad;
        logic            plot;
        logic [2:0]      colour;
        logic [6:0]      y;
        logic [7:0]      x;
    } draw_instr_t;

    function automatic logic [OP_W-1:0] instr_op(input logic [INSTRUCTION_WIDTH-1:0] instr);
        return instr[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/dp_request_arbiter_picker.sv
// Combinational round-robin picker: first set request scanning last+1, last+2, ... modulo NUM_REQ.
module rr_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    // Scan from farthest to nearest so the nearest candidate after last wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(last) + k) % NUM_REQ]) begin
                any = 1'b1;
                idx = IDX_W'((int'(last) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/dp_request_arbiter.sv
// Round-robin arbiter sharing one draw datapath among NUM_REQ clients, one instruction in flight.
// Issue: pulse start, wait for finished (with timeout), return result/ack to the granted client only.
module dp_request_arbiter
    import dp_request_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2,
    parameter int TIMEOUT = 4096,
    parameter int INSTR_W = INSTRUCTION_WIDTH,
    parameter int RES_W   = RESULT_WIDTH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*INSTR_W-1:0] req_instruction,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic [RES_W-1:0]           req_result,
    output logic                       req_error,
    output logic                       busy,
    output logic [IDX_W-1:0]           grant_id,
    output logic                       start_dp,
    output logic [INSTR_W-1:0]         instruction_dp,
    input  logic                       finished_dp,
    input  logic [RES_W-1:0]           result_dp
);

    localparam int CNT_W = $clog2(TIMEOUT);

    dparb_state_e        state_q, state_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic                start_q, start_d;
    logic                busy_q, busy_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [RES_W-1:0]    result_q, result_d;
    logic                error_q, error_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                pick_any;
    logic [IDX_W-1:0]    pick_idx;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req  (req_valid),
        .last (last_q),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        instr_d  = instr_q;
        start_d  = 1'b0;
        busy_d   = busy_q;
        ack_d    = '0;
        result_d = result_q;
        error_d  = error_q;
        cnt_d    = cnt_q;

        case (state_q)
            DPARB_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    last_d  = pick_idx;
                    instr_d = req_instruction[pick_idx*INSTR_W +: INSTR_W];
                    busy_d  = 1'b1;
                    start_d = 1'b1;
                    state_d = DPARB_ISSUE;
                end
            end
            DPARB_ISSUE: begin
                state_d = DPARB_SETTLE;
            end
            // finished_dp is still stale here; the datapath drops it a cycle after start.
            DPARB_SETTLE: begin
                cnt_d   = '0;
                state_d = DPARB_WAIT;
            end
            DPARB_WAIT: begin
                if (finished_dp) begin
                    result_d = result_dp;
                    error_d  = 1'b0;
                    ack_d    = NUM_REQ'(1) << grant_q;
                    state_d  = DPARB_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    result_d = '0;
                    error_d  = 1'b1;
                    ack_d    = NUM_REQ'(1) << grant_q;
                    state_d  = DPARB_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DPARB_RESP: begin
                busy_d  = 1'b0;
                state_d = DPARB_IDLE;
            end
            default: begin
                state_d = DPARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= DPARB_IDLE;
            grant_q  <= '0;
            last_q   <= IDX_W'(NUM_REQ - 1);
            instr_q  <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            ack_q    <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            instr_q  <= instr_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
            result_q <= result_d;
            error_q  <= error_d;
            cnt_q    <= cnt_d;
        end
    end

    assign req_ack        = ack_q;
    assign req_result     = result_q;
    assign req_error      = error_q;
    assign busy           = busy_q;
    assign grant_id       = grant_q;
    assign start_dp       = start_q;
    assign instruction_dp = instr_q;

endmodule
